pcd8544_spi_rx: RTL and testbench

Display-side receiver for the PCD8544 (84x48 Nokia-style LCD) serial link driven by our `spi_master` outputs (`sclk`, `mosi`, `sce`, `dc`, `rst`). It deserialises bytes and decodes command bytes into controller state. It writes data bytes into an internal 504-byte display RAM with PCD8544 address auto-increment. It serves as the behavioural display endpoint for board-less regression and as a frame snooper for on-chip checking.

---
 rtl/pcd8544_spi_rx.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_pcd8544_spi_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcd8544_spi_rx.sv
// pcd8544_spi_rx: display-side receiver for the PCD8544 serial link.
// It synchronises sclk/mosi/sce/dc/rst into the system clock domain and
// deserialises bytes MSB first. Command bytes are decoded into controller
// state. Data bytes are written into a 504-byte display RAM, and the
// cursor then auto-increments.
// Optional feature macro: PCD_EXT_CMD_EN. When it is defined, the H=1
// extended commands load vop, bias and tc. When it is undefined, those
// three outputs are tied to 0.

module pcd8544_spi_rx #(
    parameter int COLS        = 84,
    parameter int ROWS        = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       sce,
    input  logic       dc,
    input  logic       rst,
    input  logic [8:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_is_data,
    output logic [6:0] cur_x,
    output logic [2:0] cur_y,
    output logic       func_pd,
    output logic       func_v,
    output logic       func_h,
    output logic [1:0] disp_mode,
    output logic [6:0] vop,
    output logic [2:0] bias,
    output logic [1:0] tc
);

    localparam int         RAM_DEPTH = COLS * ROWS;
    localparam logic [6:0] X_MAX     = 7'(COLS - 1);
    localparam logic [2:0] Y_MAX     = 3'(ROWS - 1);
    localparam logic [8:0] RAM_LAST  = 9'(RAM_DEPTH - 1);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] sce_sync_q;
    logic [SYNC_STAGES-1:0] dc_sync_q;
    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic                   sclk_prev_q;

    logic sclk_s, mosi_s, sce_s, dc_s, rst_s, sclk_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sce_s     = sce_sync_q[SYNC_STAGES-1];
    assign dc_s      = dc_sync_q[SYNC_STAGES-1];
    assign rst_s     = rst_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    // Shift every serial input through its synchroniser chain. mosi and dc
    // use the same depth as sclk, so data and clock stay aligned.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments only, so every
        // flop samples the values from before the edge, whatever order the
        // statements are written in.
        if (!Reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sce_sync_q  <= '1;
            dc_sync_q   <= '0;
            rst_sync_q  <= '1;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sce_sync_q  <= {sce_sync_q[SYNC_STAGES-2:0], sce};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], dc};
            rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], rst};
            sclk_prev_q <= sclk_s;
        end
    end

    // ------------------------------------------------------------------
    // Deserialiser
    // ------------------------------------------------------------------
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_is_data_q, byte_is_data_d;

    // Next-state logic for the shifter. A high sce or a low rst overrides
    // any sclk edge, so a partial byte is dropped and no pulse is produced.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        byte_valid_d   = 1'b0;
        byte_out_d     = byte_out_q;
        byte_is_data_d = byte_is_data_q;

        if (!rst_s || sce_s) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            shift_d   = {shift_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_out_d     = {shift_q[6:0], mosi_s};
                byte_is_data_d = dc_s;
                byte_valid_d   = 1'b1;
            end
        end
    end

    // Deserialiser state register.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            byte_valid_q   <= 1'b0;
            byte_out_q     <= '0;
            byte_is_data_q <= 1'b0;
        end else begin
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            byte_valid_q   <= byte_valid_d;
            byte_out_q     <= byte_out_d;
            byte_is_data_q <= byte_is_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Command decode and cursor
    // ------------------------------------------------------------------
    logic [6:0] x_q, x_d;
    logic [2:0] y_q, y_d;
    logic       pd_q, pd_d;
    logic       v_q, v_d;
    logic       h_q, h_d;
    logic [1:0] disp_q, disp_d;
`ifdef PCD_EXT_CMD_EN
    logic [6:0] vop_q, vop_d;
    logic [2:0] bias_q, bias_d;
    logic [1:0] tc_q, tc_d;
`endif

    logic [7:0] cmd;
    assign cmd = byte_out_q;

    // Decode the byte that byte_valid presents. The effects show up in the
    // following cycle. A low display reset has priority over any decode.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        pd_d   = pd_q;
        v_d    = v_q;
        h_d    = h_q;
        disp_d = disp_q;
`ifdef PCD_EXT_CMD_EN
        vop_d  = vop_q;
        bias_d = bias_q;
        tc_d   = tc_q;
`endif

        if (!rst_s) begin
            x_d    = '0;
            y_d    = '0;
            pd_d   = 1'b1;
            v_d    = 1'b0;
            h_d    = 1'b0;
            disp_d = 2'b00;
`ifdef PCD_EXT_CMD_EN
            vop_d  = '0;
            bias_d = '0;
            tc_d   = '0;
`endif
        end else if (byte_valid_q) begin
            if (byte_is_data_q) begin
                if (!v_q) begin
                    // Horizontal addressing: step X and carry into Y.
                    if (x_q == X_MAX) begin
                        x_d = '0;
                        y_d = (y_q == Y_MAX) ? 3'd0 : y_q + 3'd1;
                    end else begin
                        x_d = x_q + 7'd1;
                    end
                end else begin
                    // Vertical addressing: step Y and carry into X.
                    if (y_q == Y_MAX) begin
                        y_d = '0;
                        x_d = (x_q == X_MAX) ? 7'd0 : x_q + 7'd1;
                    end else begin
                        y_d = y_q + 3'd1;
                    end
                end
            end else if (cmd[7:3] == 5'b00100) begin
                // Function set decodes in both instruction sets.
                pd_d = cmd[2];
                v_d  = cmd[1];
                h_d  = cmd[0];
            end else if (!h_q) begin
                if (cmd[7]) begin
                    if (cmd[6:0] <= X_MAX) begin
                        x_d = cmd[6:0];
                    end
                end else if (cmd[7:3] == 5'b01000) begin
                    if (cmd[2:0] <= Y_MAX) begin
                        y_d = cmd[2:0];
                    end
                end else if (cmd[7:3] == 5'b00001 && !cmd[1]) begin
                    disp_d = {cmd[2], cmd[0]};
                end
            end
`ifdef PCD_EXT_CMD_EN
            else begin
                if (cmd[7]) begin
                    vop_d = cmd[6:0];
                end else if (cmd[7:3] == 5'b00010) begin
                    bias_d = cmd[2:0];
                end else if (cmd[7:2] == 6'b000001) begin
                    tc_d = cmd[1:0];
                end
            end
`endif
        end
    end

    // Controller state register.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            x_q    <= '0;
            y_q    <= '0;
            pd_q   <= 1'b1;
            v_q    <= 1'b0;
            h_q    <= 1'b0;
            disp_q <= 2'b00;
`ifdef PCD_EXT_CMD_EN
            vop_q  <= '0;
            bias_q <= '0;
            tc_q   <= '0;
`endif
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            pd_q   <= pd_d;
            v_q    <= v_d;
            h_q    <= h_d;
            disp_q <= disp_d;
`ifdef PCD_EXT_CMD_EN
            vop_q  <= vop_d;
            bias_q <= bias_d;
            tc_q   <= tc_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Display RAM
    // ------------------------------------------------------------------
    logic [7:0] ram_q [RAM_DEPTH];
    logic [8:0] wr_addr;
    logic       ram_we;
    logic [7:0] rd_data_q;

    // The cursor is always in range, so wr_addr never exceeds RAM_LAST.
    assign wr_addr = 9'(y_q) * 9'(COLS) + 9'(x_q);
    assign ram_we  = Reset && rst_s && byte_valid_q && byte_is_data_q;

    // Write the data byte at the cursor position.
    always_ff @(posedge clock) begin
        // NOTE: the RAM array has no reset. Clearing 504 entries would need
        // a reset fan-out on every word, and the display RAM is undefined at
        // power-up anyway.
        if (ram_we) begin
            ram_q[wr_addr] <= byte_out_q;
        end
    end

    // Registered read port. It is read-first against a same-cycle write,
    // and addresses beyond the array return 0.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            rd_data_q <= '0;
        end else if (rd_addr <= RAM_LAST) begin
            rd_data_q <= ram_q[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_data      = rd_data_q;
    assign byte_valid   = byte_valid_q;
    assign byte_out     = byte_out_q;
    assign byte_is_data = byte_is_data_q;
    assign cur_x        = x_q;
    assign cur_y        = y_q;
    assign func_pd      = pd_q;
    assign func_v       = v_q;
    assign func_h       = h_q;
    assign disp_mode    = disp_q;
`ifdef PCD_EXT_CMD_EN
    assign vop          = vop_q;
    assign bias         = bias_q;
    assign tc           = tc_q;
`else
    assign vop          = '0;
    assign bias         = '0;
    assign tc           = '0;
`endif

endmodule

// File: tb/tb_pcd8544_spi_rx.sv
// Testbench for pcd8544_spi_rx. It drives directed serial bytes. A
// scoreboard queue holds the expected byte stream, and a monitor compares it
// against every byte_valid pulse. Directed checks cover controller state and
// RAM contents.
`timescale 1ns/1ps

module tb_pcd8544_spi_rx;

    logic       clock = 1'b0;
    logic       Reset;
    logic       sclk, mosi, sce, dc, rst;
    logic [8:0] rd_addr;
    logic [7:0] rd_data;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       byte_is_data;
    logic [6:0] cur_x;
    logic [2:0] cur_y;
    logic       func_pd, func_v, func_h;
    logic [1:0] disp_mode;
    logic [6:0] vop;
    logic [2:0] bias;
    logic [1:0] tc;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] b;
        logic       dc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    pcd8544_spi_rx #(.COLS(84), .ROWS(6), .SYNC_STAGES(2)) dut (
        .clock        (clock),
        .Reset        (Reset),
        .sclk         (sclk),
        .mosi         (mosi),
        .sce          (sce),
        .dc           (dc),
        .rst          (rst),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .byte_valid   (byte_valid),
        .byte_out     (byte_out),
        .byte_is_data (byte_is_data),
        .cur_x        (cur_x),
        .cur_y        (cur_y),
        .func_pd      (func_pd),
        .func_v       (func_v),
        .func_h       (func_h),
        .disp_mode    (disp_mode),
        .vop          (vop),
        .bias         (bias),
        .tc           (tc)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Clock out the top n bits of b, MSB first. Only complete bytes are
    // expected to produce a pulse, so only those go into the scoreboard.
    task automatic send_bits(input logic [7:0] b, input logic d, input int n);
        exp_t e;
        if (n == 8) begin
            e.b  = b;
            e.dc = d;
            sb.push_back(e);
        end
        sce = 1'b0;
        wait_clk(2);
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            dc   = d;
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        wait_clk(4);
        sce = 1'b1;
        wait_clk(4);
    endtask

    task automatic cmd(input logic [7:0] b);
        send_bits(b, 1'b0, 8);
    endtask

    task automatic dat(input logic [7:0] b);
        send_bits(b, 1'b1, 8);
    endtask

    task automatic check_ram(input string name, input logic [8:0] a, input logic [7:0] exp);
        rd_addr = a;
        wait_clk(1);
        check(name, {24'd0, rd_data}, {24'd0, exp});
    endtask

    // Monitor: each byte_valid pulse pops the next expected byte.
    always @(negedge clock) begin
        if (Reset && byte_valid) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_pulse: got byte 0x%0h, expected no pulse (t=%0t)", byte_out, $time);
            end else begin
                mon_e = sb.pop_front();
                check("byte_out", {24'd0, byte_out}, {24'd0, mon_e.b});
                check("byte_is_data", {31'd0, byte_is_data}, {31'd0, mon_e.dc});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset   = 1'b0;
        sclk    = 1'b0;
        mosi    = 1'b0;
        sce     = 1'b1;
        dc      = 1'b0;
        rst     = 1'b1;
        rd_addr = '0;
        wait_clk(5);

        // Reset values
        check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_byte_out", {24'd0, byte_out}, 32'd0);
        check("rst_byte_is_data", {31'd0, byte_is_data}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_cur_x", {25'd0, cur_x}, 32'd0);
        check("rst_cur_y", {29'd0, cur_y}, 32'd0);
        check("rst_func_pd", {31'd0, func_pd}, 32'd1);
        check("rst_func_v", {31'd0, func_v}, 32'd0);
        check("rst_func_h", {31'd0, func_h}, 32'd0);
        check("rst_disp_mode", {30'd0, disp_mode}, 32'd0);
        check("rst_vop", {25'd0, vop}, 32'd0);
        check("rst_bias", {29'd0, bias}, 32'd0);
        check("rst_tc", {30'd0, tc}, 32'd0);

        Reset = 1'b1;
        wait_clk(4);

        // Init sequence: extended mode, Vop, basic mode, normal display
        cmd(8'h21);
        check("init_h_set", {31'd0, func_h}, 32'd1);
        check("init_pd_set", {31'd0, func_pd}, 32'd0);
        cmd(8'h90);
        check("init_x_not_set_in_ext", {25'd0, cur_x}, 32'd0);
`ifdef PCD_EXT_CMD_EN
        check("init_vop", {25'd0, vop}, 32'h10);
`else
        check("init_vop", {25'd0, vop}, 32'h00);
`endif
        cmd(8'h20);
        check("init_h_clear", {31'd0, func_h}, 32'd0);
        cmd(8'h0C);
        check("init_disp_mode", {30'd0, disp_mode}, 32'd2);
        check("init_pd", {31'd0, func_pd}, 32'd0);

        // Horizontal writes at origin
        cmd(8'h80);
        cmd(8'h40);
        dat(8'h30);
        dat(8'h48);
        check("h_cur_x", {25'd0, cur_x}, 32'd2);
        check("h_cur_y", {29'd0, cur_y}, 32'd0);
        check_ram("h_ram0", 9'd0, 8'h30);
        check_ram("h_ram1", 9'd1, 8'h48);

        // Last cell, with the cursor wrapping to the origin
        cmd(8'hD3);
        cmd(8'h45);
        check("last_cur_x_set", {25'd0, cur_x}, 32'd83);
        check("last_cur_y_set", {29'd0, cur_y}, 32'd5);
        dat(8'hAA);
        check("last_cur_x", {25'd0, cur_x}, 32'd0);
        check("last_cur_y", {29'd0, cur_y}, 32'd0);
        check_ram("last_ram503", 9'd503, 8'hAA);

        // Vertical addressing
        cmd(8'h22);
        check("v_func_v", {31'd0, func_v}, 32'd1);
        cmd(8'h45);
        cmd(8'h80);
        dat(8'h11);
        dat(8'h22);
        check("v_cur_x", {25'd0, cur_x}, 32'd1);
        check("v_cur_y", {29'd0, cur_y}, 32'd1);
        check_ram("v_ram420", 9'd420, 8'h11);
        check_ram("v_ram1", 9'd1, 8'h22);

        // Partial byte aborted by sce, then a full byte
        send_bits(8'hF8, 1'b0, 5);
        cmd(8'h0D);
        check("partial_byte_out", {24'd0, byte_out}, 32'h0D);
        check("partial_disp_mode", {30'd0, disp_mode}, 32'd3);

        // Out-of-range X/Y are ignored but still pulse
        cmd(8'hD5);
        cmd(8'h47);
        check("oor_cur_x", {25'd0, cur_x}, 32'd1);
        check("oor_cur_y", {29'd0, cur_y}, 32'd1);

        // Reads past the end of the RAM return 0
        check_ram("oob_504", 9'd504, 8'h00);
        check_ram("oob_511", 9'd511, 8'h00);

        // Display reset: state returns to defaults and the RAM is kept
        rst = 1'b0;
        wait_clk(6);
        rst = 1'b1;
        wait_clk(4);
        check("drst_cur_x", {25'd0, cur_x}, 32'd0);
        check("drst_cur_y", {29'd0, cur_y}, 32'd0);
        check("drst_func_pd", {31'd0, func_pd}, 32'd1);
        check("drst_func_v", {31'd0, func_v}, 32'd0);
        check("drst_disp_mode", {30'd0, disp_mode}, 32'd0);
        check_ram("drst_ram420", 9'd420, 8'h11);
        check_ram("drst_ram503", 9'd503, 8'hAA);

        wait_clk(4);
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
